// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a common-anode
//                seven-segment display. Sequences digit slots at a fixed
//                rate with an anode-off ghost-suppression gap, snapshots
//                the displayed value once per frame, and performs hex
//                decode with optional leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int N_DIG     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  dig_mask,
  input  logic        lz_blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        scan_tick
);

  // --------------------------------------------------------------------------
  // State encoding and derived constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  // Last count value of each phase; cnt restarts at 0 on every state entry.
  localparam logic [31:0] c_drive_last = 32'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [31:0] c_blank_last = 32'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [2:0]  c_last_idx   = 3'(N_DIG - 1);
  localparam bit          c_has_blank  = (BLANK_CYC > 0);

  localparam logic [7:0]  c_an_off     = 8'hFF;
  localparam logic [6:0]  c_seg_off    = 7'h7F;

  // Hex to active-high segment pattern, bit order gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_idx;
  logic [31:0] r_snap;

  logic [1:0]  w_state_nx;
  logic [31:0] w_cnt_nx;
  logic [2:0]  w_idx_nx;
  logic [31:0] w_snap_nx;
  logic        w_slot_start;

  logic        w_wrap;
  logic [2:0]  w_idx_adv;

  // Next-output values; outputs are registered from these so that the
  // pattern for a new state appears on the same edge the state changes.
  logic [7:0]  w_an_nx;
  logic [6:0]  w_seg_nx;
  logic        w_dp_n_nx;
  logic        w_upper_zero;
  logic        w_lit;
  logic [3:0]  w_nib;

  assign w_wrap    = (r_idx == c_last_idx);
  assign w_idx_adv = w_wrap ? 3'd0 : (r_idx + 3'd1);

  // State register: sequencer state, slot counter, digit index and snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_snap  <= w_snap_nx;
    end
  end

  // Next-state logic: slot timing, digit advance and frame snapshot on wrap.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 32'd1;
    w_idx_nx     = r_idx;
    w_snap_nx    = r_snap;
    w_slot_start = 1'b0;
    if (!en) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Fresh start: digit 0 with a new snapshot of the live value.
          w_state_nx   = S_DRIVE;
          w_cnt_nx     = '0;
          w_idx_nx     = '0;
          w_snap_nx    = data;
          w_slot_start = 1'b1;
        end
        S_DRIVE: begin
          if (r_cnt == c_drive_last) begin
            w_cnt_nx = '0;
            if (c_has_blank) begin
              w_state_nx = S_BLANK;
            end else begin
              // No gap configured: step straight into the next digit.
              w_idx_nx     = w_idx_adv;
              w_slot_start = 1'b1;
              if (w_wrap) begin
                w_snap_nx = data;
              end
            end
          end
        end
        S_BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nx   = S_DRIVE;
            w_cnt_nx     = '0;
            w_idx_nx     = w_idx_adv;
            w_slot_start = 1'b1;
            if (w_wrap) begin
              w_snap_nx = data;
            end
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
      endcase
    end
  end

  // Output decode: lit-digit rule, leading-zero test against the snapshot.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((j >= int'(w_idx_nx)) && (j < N_DIG) && (w_snap_nx[4*j +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
    w_nib = w_snap_nx[{w_idx_nx, 2'b00} +: 4];
    w_lit = (w_state_nx == S_DRIVE) && dig_mask[w_idx_nx] &&
            !(lz_blank && (w_idx_nx != 3'd0) && w_upper_zero);
    w_an_nx   = c_an_off;
    w_seg_nx  = c_seg_off;
    w_dp_n_nx = 1'b1;
    if (w_lit) begin
      w_an_nx   = ~(8'h01 << w_idx_nx);
      w_seg_nx  = ~hex7(w_nib);
      w_dp_n_nx = ~dp[w_idx_nx];
    end
  end

  // Output register: every display pin and the slot tick come from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an        <= c_an_off;
      seg       <= c_seg_off;
      dp_n      <= 1'b1;
      scan_tick <= 1'b0;
    end else begin
      an        <= w_an_nx;
      seg       <= w_seg_nx;
      dp_n      <= w_dp_n_nx;
      scan_tick <= w_slot_start;
    end
  end

endmodule
`default_nettype wire
